// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback for the 5-stage MIPS core.
// Waits for variable-latency loads, then extends/aligns load data for the register file.
module wb_stage #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic [31:0] ALUOutM,
    input  logic [4:0]  WriteRegM,
    input  logic [2:0]  LoadTypeM,
    input  logic [31:0] ReadDataM,
    input  logic        RdValidM,
    input  logic        FlushW,
    output logic        RegWriteW,
    output logic [4:0]  WriteRegW,
    output logic [31:0] ResultW,
    output logic        StallM,
    output logic        AdelW,
    output logic        TimeoutW
);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    // Fields of the outstanding load, held while waiting for the response.
    logic [1:0]       off_q;
    logic [2:0]       lt_q;
    logic [4:0]       wreg_q;
    logic             regw_q;
    logic             lat_en;

    logic             w_regw;
    logic [4:0]       w_wreg;
    logic [31:0]      w_res;
    logic             adel_set, to_set;

    function automatic logic [31:0] ext_load(input logic [2:0] lt, input logic [1:0] o,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*o +: 8];
        h = o[1] ? d[31:16] : d[15:0];
        case (lt)
            3'b001:  ext_load = {{24{b[7]}}, b};
            3'b010:  ext_load = {24'h0, b};
            3'b011:  ext_load = {{16{h[15]}}, h};
            3'b100:  ext_load = {16'h0, h};
            default: ext_load = d;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] lt, input logic [1:0] o);
        case (lt)
            3'b001, 3'b010: misaligned = 1'b0;
            3'b011, 3'b100: misaligned = o[0];
            default:        misaligned = (o != 2'b00);
        endcase
    endfunction

    assign StallM = (state == S_WAIT);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        w_regw   = 1'b0;
        w_wreg   = 5'd0;
        w_res    = 32'd0;
        adel_set = 1'b0;
        to_set   = 1'b0;
        lat_en   = 1'b0;
        if (FlushW) begin
            state_n = S_RUN;
            cnt_n   = '0;
        end else if (state == S_RUN) begin
            if (!MemtoRegM) begin
                w_regw = RegWriteM;
                w_wreg = WriteRegM;
                w_res  = ALUOutM;
            end else if (misaligned(LoadTypeM, ALUOutM[1:0])) begin
                adel_set = 1'b1;
            end else if (RdValidM) begin
                w_regw = RegWriteM;
                w_wreg = WriteRegM;
                w_res  = ext_load(LoadTypeM, ALUOutM[1:0], ReadDataM);
            end else begin
                state_n = S_WAIT;
                cnt_n   = CNT_W'(1);
                lat_en  = 1'b1;
            end
        end else begin
            if (RdValidM) begin
                w_regw  = regw_q;
                w_wreg  = wreg_q;
                w_res   = ext_load(lt_q, off_q, ReadDataM);
                state_n = S_RUN;
                cnt_n   = '0;
            end else if (cnt >= CNT_MAX) begin
                to_set  = 1'b1;
                state_n = S_RUN;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
    end

    // W stage registers; writes to $0 are suppressed here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            cnt       <= '0;
            RegWriteW <= 1'b0;
            WriteRegW <= 5'd0;
            ResultW   <= 32'd0;
            AdelW     <= 1'b0;
            TimeoutW  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            RegWriteW <= w_regw & (w_wreg != 5'd0);
            WriteRegW <= w_wreg;
            ResultW   <= w_res;
            AdelW     <= AdelW | adel_set;
            TimeoutW  <= TimeoutW | to_set;
        end
    end

    always_ff @(posedge clk) begin
        if (lat_en) begin
            off_q  <= ALUOutM[1:0];
            lt_q   <= LoadTypeM;
            wreg_q <= WriteRegM;
            regw_q <= RegWriteM;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: ALU writeback, load extension, wait/timeout,
// misalignment, flush and $0 handling, with hand-computed expectations.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteM, MemtoRegM, RdValidM, FlushW;
    logic [31:0] ALUOutM, ReadDataM;
    logic [4:0]  WriteRegM;
    logic [2:0]  LoadTypeM;
    logic        RegWriteW, StallM, AdelW, TimeoutW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;

    int checks = 0;
    int errors = 0;

    wb_stage #(.WAIT_MAX(15), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .ALUOutM(ALUOutM),
        .WriteRegM(WriteRegM), .LoadTypeM(LoadTypeM), .ReadDataM(ReadDataM),
        .RdValidM(RdValidM), .FlushW(FlushW),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .StallM(StallM), .AdelW(AdelW), .TimeoutW(TimeoutW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic rw, input logic [4:0] wr, input logic [31:0] res);
        RegWriteM = rw; MemtoRegM = 1'b0; WriteRegM = wr; ALUOutM = res;
        LoadTypeM = 3'b000; RdValidM = 1'b0; FlushW = 1'b0;
    endtask

    task automatic load(input logic [2:0] lt, input logic [31:0] addr, input logic [4:0] wr,
                        input logic [31:0] data, input logic vld);
        RegWriteM = 1'b1; MemtoRegM = 1'b1; WriteRegM = wr; ALUOutM = addr;
        LoadTypeM = lt; ReadDataM = data; RdValidM = vld; FlushW = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        alu(1'b0, 5'd0, 32'd0);
        ReadDataM = 32'd0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_regw", {31'd0, RegWriteW}, 32'd0);
        chk("rst_stall", {31'd0, StallM}, 32'd0);
        chk("rst_flags", {30'd0, AdelW, TimeoutW}, 32'd0);

        // ALU writeback, then asynchronous reset mid-cycle
        alu(1'b1, 5'd8, 32'h1234);
        step();
        chk("alu_regw", {31'd0, RegWriteW}, 32'd1);
        chk("alu_wreg", {27'd0, WriteRegW}, 32'd8);
        chk("alu_res", ResultW, 32'h0000_1234);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_regw", {31'd0, RegWriteW}, 32'd0);
        chk("async_rst_res", ResultW, 32'd0);
        chk("async_rst_wreg", {27'd0, WriteRegW}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_alu", ResultW, 32'h0000_1234);

        // Zero-wait loads
        load(3'b001, 32'h0000_0103, 5'd9, 32'h80FF_0000, 1'b1);
        step();
        chk("lb_o3", ResultW, 32'hFFFF_FF80);
        chk("lb_o3_stall", {31'd0, StallM}, 32'd0);
        chk("lb_o3_regw", {31'd0, RegWriteW}, 32'd1);
        load(3'b100, 32'h0000_0102, 5'd9, 32'h80FF_0000, 1'b1);
        step();
        chk("lhu_o2", ResultW, 32'h0000_80FF);
        load(3'b011, 32'h0000_0102, 5'd9, 32'h80FF_0000, 1'b1);
        step();
        chk("lh_o2", ResultW, 32'hFFFF_80FF);
        load(3'b010, 32'h0000_0102, 5'd9, 32'h80FF_0000, 1'b1);
        step();
        chk("lbu_o2", ResultW, 32'h0000_00FF);

        // Wait path: three cycles without RdValidM
        load(3'b000, 32'h0000_0100, 5'd10, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_stall", {31'd0, StallM}, 32'd1);
            chk("wait_regw", {31'd0, RegWriteW}, 32'd0);
        end
        ReadDataM = 32'hDEAD_BEEF;
        RdValidM  = 1'b1;
        step();
        chk("wait_regw_done", {31'd0, RegWriteW}, 32'd1);
        chk("wait_res", ResultW, 32'hDEAD_BEEF);
        chk("wait_wreg", {27'd0, WriteRegW}, 32'd10);
        chk("wait_stall_drop", {31'd0, StallM}, 32'd0);
        alu(1'b0, 5'd0, 32'd0);
        step();
        chk("wait_stall_after", {31'd0, StallM}, 32'd0);

        // Latched offset/type/dest used even though M inputs change during the wait
        load(3'b001, 32'h0000_0201, 5'd11, 32'h0, 1'b0);
        step();
        ALUOutM = 32'h0000_0200; LoadTypeM = 3'b000; WriteRegM = 5'd5;
        ReadDataM = 32'h1234_5678; RdValidM = 1'b1;
        step();
        chk("latch_res", ResultW, 32'h0000_0056);
        chk("latch_wreg", {27'd0, WriteRegW}, 32'd11);

        // Timeout after WAIT_MAX cycles
        load(3'b000, 32'h0000_0300, 5'd12, 32'h0, 1'b0);
        step();
        for (int i = 0; i < 14; i++) step();
        chk("to_not_yet", {31'd0, TimeoutW}, 32'd0);
        chk("to_still_stall", {31'd0, StallM}, 32'd1);
        step();
        chk("to_flag", {31'd0, TimeoutW}, 32'd1);
        chk("to_regw", {31'd0, RegWriteW}, 32'd0);
        chk("to_run", {31'd0, StallM}, 32'd0);
        alu(1'b1, 5'd13, 32'h0000_0ABC);
        step();
        chk("to_alu_regw", {31'd0, RegWriteW}, 32'd1);
        chk("to_alu_res", ResultW, 32'h0000_0ABC);
        chk("to_sticky", {31'd0, TimeoutW}, 32'd1);

        // Misaligned loads
        load(3'b011, 32'h0000_1001, 5'd14, 32'hFFFF_FFFF, 1'b1);
        step();
        chk("lh_mis_adel", {31'd0, AdelW}, 32'd1);
        chk("lh_mis_regw", {31'd0, RegWriteW}, 32'd0);
        chk("lh_mis_stall", {31'd0, StallM}, 32'd0);
        do_reset();
        chk("rst_clears_flags", {30'd0, AdelW, TimeoutW}, 32'd0);
        load(3'b000, 32'h0000_1002, 5'd14, 32'hFFFF_FFFF, 1'b0);
        step();
        chk("lw_mis_adel", {31'd0, AdelW}, 32'd1);
        chk("lw_mis_regw", {31'd0, RegWriteW}, 32'd0);
        chk("lw_mis_stall", {31'd0, StallM}, 32'd0);

        // Flush beats RdValidM during WAIT
        load(3'b000, 32'h0000_0400, 5'd15, 32'h0, 1'b0);
        step();
        chk("fl_wait_stall", {31'd0, StallM}, 32'd1);
        ReadDataM = 32'h0000_0055; RdValidM = 1'b1; FlushW = 1'b1;
        step();
        chk("fl_regw", {31'd0, RegWriteW}, 32'd0);
        chk("fl_res", ResultW, 32'd0);
        chk("fl_wreg", {27'd0, WriteRegW}, 32'd0);
        chk("fl_stall", {31'd0, StallM}, 32'd0);

        // Flush of an ALU op in RUN
        alu(1'b1, 5'd3, 32'h0000_0033);
        FlushW = 1'b1;
        step();
        chk("fl_alu_regw", {31'd0, RegWriteW}, 32'd0);

        // Writes to $0 suppressed; RdValidM ignored for non-loads
        alu(1'b1, 5'd0, 32'h0000_0077);
        RdValidM = 1'b1; ReadDataM = 32'hCAFE_F00D;
        step();
        chk("r0_regw", {31'd0, RegWriteW}, 32'd0);
        alu(1'b1, 5'd4, 32'h0000_0044);
        RdValidM = 1'b1; ReadDataM = 32'hCAFE_F00D;
        step();
        chk("rdv_ignored_res", ResultW, 32'h0000_0044);
        chk("rdv_ignored_stall", {31'd0, StallM}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
